// File: rtl/mem_access_stage.sv
// LEGv8 MEM stage: 64-bit LDUR/STUR against an internal data memory with LAT-cycle access.
// Define MEM_ACCESS_COUNT_EN to add the load_count/store_count completion counters.
module mem_access_stage #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned LAT   = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        valid_in,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        regWrite,
    input  logic        memtoReg,
    input  logic [63:0] alu_result,
    input  logic [63:0] write_data,
    input  logic [4:0]  write_reg,
    input  logic [31:0] instruction,
    output logic        stall,
    output logic        valid_out,
    output logic [63:0] read_data,
    output logic [63:0] alu_result_out,
    output logic [4:0]  write_reg_out,
    output logic        regWrite_out,
    output logic        memtoReg_out,
    output logic [31:0] instruction_out,
    output logic        mem_fault
`ifdef MEM_ACCESS_COUNT_EN
    ,
    output logic [31:0] load_count,
    output logic [31:0] store_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(LAT) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] cnt_q;

    logic [63:0]   addr_q, wdata_q;
    logic          rd_q, wr_q, regw_q, m2r_q;
    logic [4:0]    wreg_q;
    logic [31:0]   instr_q;

    logic [63:0]   mem [DEPTH];

    // The access being worked on: live inputs in IDLE, the captured copy in BUSY.
    logic [63:0]   acc_addr, acc_wdata;
    logic          acc_rd, acc_wr, acc_regw, acc_m2r;
    logic [4:0]    acc_wreg;
    logic [31:0]   acc_instr;

    always_comb begin
        acc_addr  = alu_result;
        acc_wdata = write_data;
        acc_rd    = memRead;
        acc_wr    = memWrite;
        acc_regw  = regWrite;
        acc_m2r   = memtoReg;
        acc_wreg  = write_reg;
        acc_instr = instruction;
        if (state == BUSY) begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_rd    = rd_q;
            acc_wr    = wr_q;
            acc_regw  = regw_q;
            acc_m2r   = m2r_q;
            acc_wreg  = wreg_q;
            acc_instr = instr_q;
        end
    end

    logic          mem_op, in_range, fault, complete, mem_we;
    logic [AW-1:0] acc_idx;
    logic [63:0]   fin_rdata;

    assign mem_op    = acc_rd | acc_wr;
    assign acc_idx   = acc_addr[AW+2:3];
    assign in_range  = (acc_addr >> 3) < 64'(DEPTH);
    assign fault     = mem_op & ((acc_addr[2:0] != 3'b000) | (acc_rd & acc_wr) | ~in_range);
    assign complete  = ((state == IDLE) && valid_in && (!mem_op || LAT == 1))
                     || ((state == BUSY) && (cnt_q == CW'(1)));
    assign mem_we    = complete & acc_wr & ~fault;
    assign fin_rdata = (acc_rd && !fault) ? mem[acc_idx] : 64'd0;
    assign stall     = (state == BUSY);

    // Memory contents survive reset; an access abandoned by reset never reaches complete.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            cnt_q           <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            rd_q            <= 1'b0;
            wr_q            <= 1'b0;
            regw_q          <= 1'b0;
            m2r_q           <= 1'b0;
            wreg_q          <= '0;
            instr_q         <= '0;
            valid_out       <= 1'b0;
            read_data       <= '0;
            alu_result_out  <= '0;
            write_reg_out   <= '0;
            regWrite_out    <= 1'b0;
            memtoReg_out    <= 1'b0;
            instruction_out <= '0;
            mem_fault       <= 1'b0;
        end else begin
            mem_fault <= 1'b0;
            if (complete) begin
                state           <= IDLE;
                cnt_q           <= '0;
                valid_out       <= 1'b1;
                read_data       <= fin_rdata;
                alu_result_out  <= acc_addr;
                write_reg_out   <= acc_wreg;
                regWrite_out    <= acc_regw & ~fault;
                memtoReg_out    <= acc_m2r;
                instruction_out <= acc_instr;
                mem_fault       <= fault;
            end else if (state == IDLE && valid_in) begin
                // Multi-cycle memory op: snapshot everything, inputs are ignored until done.
                state        <= BUSY;
                cnt_q        <= CW'(LAT - 1);
                addr_q       <= alu_result;
                wdata_q      <= write_data;
                rd_q         <= memRead;
                wr_q         <= memWrite;
                regw_q       <= regWrite;
                m2r_q        <= memtoReg;
                wreg_q       <= write_reg;
                instr_q      <= instruction;
                valid_out    <= 1'b0;
                regWrite_out <= 1'b0;
            end else begin
                valid_out    <= 1'b0;
                regWrite_out <= 1'b0;
                if (state == BUSY) begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end
        end
    end

`ifdef MEM_ACCESS_COUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            load_count  <= '0;
            store_count <= '0;
        end else if (complete && !fault) begin
            if (acc_rd) begin
                load_count <= load_count + 32'd1;
            end
            if (acc_wr) begin
                store_count <= store_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: vector table driven through a scoreboard queue,
// plus a hand-written reset-during-access sequence.
module tb_mem_access_stage;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid_in = 1'b0, memRead = 1'b0, memWrite = 1'b0;
    logic        regWrite = 1'b0, memtoReg = 1'b0;
    logic [63:0] alu_result = '0, write_data = '0;
    logic [4:0]  write_reg = '0;
    logic [31:0] instruction = '0;
    logic        stall, valid_out, regWrite_out, memtoReg_out, mem_fault;
    logic [63:0] read_data, alu_result_out;
    logic [4:0]  write_reg_out;
    logic [31:0] instruction_out;
`ifdef MEM_ACCESS_COUNT_EN
    logic [31:0] load_count, store_count;
`endif

    mem_access_stage #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .valid_in(valid_in),
        .memRead(memRead),
        .memWrite(memWrite),
        .regWrite(regWrite),
        .memtoReg(memtoReg),
        .alu_result(alu_result),
        .write_data(write_data),
        .write_reg(write_reg),
        .instruction(instruction),
        .stall(stall),
        .valid_out(valid_out),
        .read_data(read_data),
        .alu_result_out(alu_result_out),
        .write_reg_out(write_reg_out),
        .regWrite_out(regWrite_out),
        .memtoReg_out(memtoReg_out),
        .instruction_out(instruction_out),
        .mem_fault(mem_fault)
`ifdef MEM_ACCESS_COUNT_EN
        ,
        .load_count(load_count),
        .store_count(store_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rd, wr, regw, m2r;
        logic [63:0] addr, wdata;
        logic [4:0]  wreg;
        logic [31:0] instr;
        logic [63:0] exp_rdata;
        logic        exp_regw, exp_fault;
    } vec_t;

    typedef struct {
        logic [63:0] rdata, alu;
        logic [4:0]  wreg;
        logic        regw, m2r, fault;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[15];
    int   checks = 0;
    int   errors = 0;
    int   exp_loads = 0;
    int   exp_stores = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic regw, input logic m2r,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [4:0] wreg, input logic [31:0] instr,
                                input logic [63:0] exp_rdata, input logic exp_regw,
                                input logic exp_fault);
        vec_t v;
        v.rd = rd; v.wr = wr; v.regw = regw; v.m2r = m2r;
        v.addr = addr; v.wdata = wdata; v.wreg = wreg; v.instr = instr;
        v.exp_rdata = exp_rdata; v.exp_regw = exp_regw; v.exp_fault = exp_fault;
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, 64'(stall), 64'd0);
        check({tag, "_valid"}, 64'(valid_out), 64'd0);
        check({tag, "_rdata"}, read_data, 64'd0);
        check({tag, "_alu"}, alu_result_out, 64'd0);
        check({tag, "_wreg"}, 64'(write_reg_out), 64'd0);
        check({tag, "_regw"}, 64'(regWrite_out), 64'd0);
        check({tag, "_m2r"}, 64'(memtoReg_out), 64'd0);
        check({tag, "_instr"}, 64'(instruction_out), 64'd0);
        check({tag, "_fault"}, 64'(mem_fault), 64'd0);
    endtask

    task automatic clear_inputs();
        valid_in = 1'b0; memRead = 1'b0; memWrite = 1'b0; regWrite = 1'b0; memtoReg = 1'b0;
        alu_result = '0; write_data = '0; write_reg = '0; instruction = '0;
    endtask

    // Drive one instruction, queue its expected result, then ride out the stall.
    task automatic issue(input vec_t v);
        int   n;
        exp_t e;
        @(negedge clock);
        valid_in = 1'b1; memRead = v.rd; memWrite = v.wr; regWrite = v.regw; memtoReg = v.m2r;
        alu_result = v.addr; write_data = v.wdata; write_reg = v.wreg; instruction = v.instr;
        e.rdata = v.exp_rdata; e.alu = v.addr; e.wreg = v.wreg; e.regw = v.exp_regw;
        e.m2r = v.m2r; e.fault = v.exp_fault; e.instr = v.instr;
        exp_q.push_back(e);
        if (!v.exp_fault && v.rd) exp_loads++;
        if (!v.exp_fault && v.wr) exp_stores++;
        @(posedge clock);
        #1;
        clear_inputs();
        if (stall) begin
            // Garbage store offered while busy must be ignored.
            valid_in = 1'b1; memWrite = 1'b1; regWrite = 1'b1;
            alu_result = 64'h40; write_data = 64'hFFFF_FFFF_FFFF_FFFF; write_reg = 5'd30;
        end
        n = 0;
        while (stall && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        clear_inputs();
        check("stall_cycles", 64'(n), (v.rd || v.wr) ? 64'(LAT - 1) : 64'd0);
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got valid_out=1, expected no output");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("read_data", read_data, mon_e.rdata);
                    check("alu_result_out", alu_result_out, mon_e.alu);
                    check("write_reg_out", 64'(write_reg_out), 64'(mon_e.wreg));
                    check("regWrite_out", 64'(regWrite_out), 64'(mon_e.regw));
                    check("memtoReg_out", 64'(memtoReg_out), 64'(mon_e.m2r));
                    check("instruction_out", 64'(instruction_out), 64'(mon_e.instr));
                    check("mem_fault", 64'(mem_fault), 64'(mon_e.fault));
                end
            end else begin
                check("fault_without_valid", 64'(mem_fault), 64'd0);
                check("regw_without_valid", 64'(regWrite_out), 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            rd  wr  rw  m2r addr                    wdata                    wreg  instr         exp_rdata                rw  flt
        vecs[0]  = mk(0,  0,  1,  0,  64'h2A,                 64'h0,                   5'd9, 32'h8B020020, 64'h0,                   1,  0);
        vecs[1]  = mk(0,  1,  0,  0,  64'h18,                 64'h0123456789ABCDEF,    5'd3, 32'hF80183E3, 64'h0,                   0,  0);
        vecs[2]  = mk(1,  0,  1,  1,  64'h18,                 64'h0,                   5'd5, 32'hF8418005, 64'h0123456789ABCDEF,    1,  0);
        vecs[3]  = mk(1,  0,  1,  1,  64'h0C,                 64'h0,                   5'd6, 32'hF840C006, 64'h0,                   0,  1);
        vecs[4]  = mk(0,  1,  0,  0,  64'h1C,                 64'hFFFF0000,            5'd4, 32'hF801C004, 64'h0,                   0,  1);
        vecs[5]  = mk(1,  0,  1,  1,  64'h18,                 64'h0,                   5'd7, 32'hF8418007, 64'h0123456789ABCDEF,    1,  0);
        vecs[6]  = mk(0,  1,  0,  0,  64'h0,                  64'h5555,                5'd2, 32'hF8000002, 64'h0,                   0,  0);
        vecs[7]  = mk(0,  1,  0,  0,  64'h800,                64'hBAD,                 5'd2, 32'hF8800002, 64'h0,                   0,  1);
        vecs[8]  = mk(1,  0,  1,  1,  64'h0,                  64'h0,                   5'd8, 32'hF8400008, 64'h5555,                1,  0);
        vecs[9]  = mk(0,  1,  0,  0,  64'h7F8,                64'hCAFEF00D,            5'd1, 32'hF87F8001, 64'h0,                   0,  0);
        vecs[10] = mk(1,  0,  1,  1,  64'h7F8,                64'h0,                   5'd10,32'hF87F800A, 64'hCAFEF00D,            1,  0);
        vecs[11] = mk(1,  1,  1,  1,  64'h20,                 64'h77,                  5'd11,32'hDEADBEEF, 64'h0,                   0,  1);
        vecs[12] = mk(0,  0,  0,  0,  64'hFFFFFFFFFFFFFFF8,   64'h0,                   5'd31,32'hCB000000, 64'h0,                   0,  0);
        vecs[13] = mk(1,  0,  1,  1,  64'h808,                64'h0,                   5'd12,32'hF880800C, 64'h0,                   0,  1);
        vecs[14] = mk(0,  0,  1,  0,  64'h0,                  64'h0,                   5'd0, 32'h8B1F03E0, 64'h0,                   1,  0);

        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            issue(vecs[i]);
            if (i % 4 == 3) begin
                @(negedge clock);
                @(negedge clock);
            end
        end

`ifdef MEM_ACCESS_COUNT_EN
        @(negedge clock);
        check("load_count", 64'(load_count), 64'(exp_loads));
        check("store_count", 64'(store_count), 64'(exp_stores));
`endif

        // Reset in the middle of a store: the store must never land.
        issue(mk(0, 1, 0, 0, 64'h10, 64'h1111, 5'd0, 32'hF8010000, 64'h0, 0, 0));
        @(negedge clock);
        valid_in = 1'b1; memWrite = 1'b1; alu_result = 64'h10; write_data = 64'hDEAD;
        @(posedge clock);
        #1;
        clear_inputs();
        check("busy_after_accept", 64'(stall), 64'd1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_all_zero("midbusy_reset");
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        exp_loads = 0;
        exp_stores = 0;
        issue(mk(1, 0, 1, 1, 64'h10, 64'h0, 5'd13, 32'hF841000D, 64'h1111, 1, 0));

        repeat (3) @(negedge clock);
`ifdef MEM_ACCESS_COUNT_EN
        check("load_count_after_reset", 64'(load_count), 64'(exp_loads));
        check("store_count_after_reset", 64'(store_count), 64'(exp_stores));
`endif
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
